// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and helpers for the 4:1 mux scan controller.
//   state_t    : controller FSM states
//   NUM_CH     : number of mux channels (fixed at 4)
//   SEL_W      : width of the mux select {s1,s0}
//   lowest_set : index of the lowest set bit of a channel mask
//   maj3       : 2-of-3 majority vote (used only with MUX_SCAN_MAJORITY_EN)
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Returns 0 for an empty mask; callers qualify with their own "none" flag.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = i[SEL_W-1:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// ---------------------------------------------------------------------------
// mux_scan_next_ch
// Combinational search for the next enabled channel.
//   mask    in  : channel enable mask
//   cur     in  : current channel
//   incl    in  : 1 = the current channel itself qualifies (first-channel
//                 search with cur=0), 0 = strictly above cur
//   next_ch out : lowest qualifying enabled channel
//   none    out : no qualifying channel exists
// ---------------------------------------------------------------------------
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              incl,
  output logic [SEL_W-1:0]  next_ch,
  output logic              none
);

  logic [NUM_CH-1:0] cand_s;

  // Keep only enabled channels at/above the current one, then pick the lowest.
  always_comb begin
    cand_s = 4'b0000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        cand_s[i] = 1'b1;
      end else begin
        cand_s[i] = 1'b0;
      end
    end
    next_ch = lowest_set(cand_s);
    none    = (cand_s == 4'b0000);
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
// Scans the enabled inputs of a 4:1 bit mux, waits a programmable settle
// time after every select change, samples mux_out and hands the assembled
// 4-bit frame downstream over valid/ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a scan when idle
//   cont         : re-scan automatically after each accepted frame
//   chan_mask    : per-channel enable (bit i = channel i)
//   dwell        : extra settle cycles after each select change
//   mux_out      : mux output (same clock domain)
//   s0, s1       : mux select LSB / MSB
//   frame_data   : bit i = sample of channel i, 0 when disabled
//   frame_valid  : frame available; frame_ready accepts it
//   busy         : high in every state except IDLE
// Build option: define MUX_SCAN_MAJORITY_EN for a 3-cycle SAMPLE with
// 2-of-3 majority voting of the captures.
// Only NUM_CH = 4 is supported.
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int DWELL_W = 4,
  parameter int NUM_CH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic               s0,
  output logic               s1,
  output logic [NUM_CH-1:0]  frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy
);

  import mux_scan_pkg::*;

  state_t             state_r;
  logic [SEL_W-1:0]   sel_r;
  logic [NUM_CH-1:0]  mask_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               cont_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [NUM_CH-1:0]  acc_r;
  logic [NUM_CH-1:0]  frame_data_r;
  logic               frame_valid_r;
  logic               busy_r;

  logic [NUM_CH-1:0]  first_mask_s;
  logic [SEL_W-1:0]   first_ch_s;
  logic               first_none_s;
  logic [SEL_W-1:0]   next_ch_s;
  logic               next_none_s;
  logic               sample_done_s;
  logic               sample_bit_s;

  // In IDLE the first channel comes from the live mask; on a continuous
  // restart it comes from the latched one.
  always_comb begin
    if (state_r == ST_IDLE) begin
      first_mask_s = chan_mask;
    end else begin
      first_mask_s = mask_r;
    end
  end

  mux_scan_next_ch u_first (
    .mask    (first_mask_s),
    .cur     (2'd0),
    .incl    (1'b1),
    .next_ch (first_ch_s),
    .none    (first_none_s)
  );

  mux_scan_next_ch u_next (
    .mask    (mask_r),
    .cur     (sel_r),
    .incl    (1'b0),
    .next_ch (next_ch_s),
    .none    (next_none_s)
  );

`ifdef MUX_SCAN_MAJORITY_EN
  logic [1:0] smp_cnt_r;
  logic [1:0] cap_r;

  // Captures the first two SAMPLE cycles; the third is voted with them live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_r <= 2'd0;
      cap_r     <= 2'b00;
    end else if ((state_r == ST_SAMPLE) && !sample_done_s) begin
      cap_r[smp_cnt_r[0]] <= mux_out;
      smp_cnt_r           <= smp_cnt_r + 2'd1;
    end else begin
      smp_cnt_r <= 2'd0;
    end
  end

  // Vote is valid on the last of the three SAMPLE cycles.
  always_comb begin
    sample_done_s = (smp_cnt_r == 2'd2);
    sample_bit_s  = maj3(cap_r[0], cap_r[1], mux_out);
  end
`else
  // Single-cycle SAMPLE: the frame bit is mux_out as seen this cycle.
  always_comb begin
    sample_done_s = 1'b1;
    sample_bit_s  = mux_out;
  end
`endif

  // Scan sequencer with registered selects, frame and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      sel_r         <= 2'd0;
      mask_r        <= 4'b0000;
      dwell_r       <= '0;
      cont_r        <= 1'b0;
      cnt_r         <= '0;
      acc_r         <= 4'b0000;
      frame_data_r  <= 4'b0000;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !first_none_s) begin
            mask_r  <= chan_mask;
            dwell_r <= dwell;
            cont_r  <= cont;
            acc_r   <= 4'b0000;
            sel_r   <= first_ch_s;
            cnt_r   <= dwell;
            busy_r  <= 1'b1;
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == '0) begin
            state_r <= ST_SAMPLE;
          end else begin
            cnt_r <= cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SAMPLE: begin
          if (sample_done_s) begin
            acc_r[sel_r] <= sample_bit_s;
            if (!next_none_s) begin
              sel_r   <= next_ch_s;
              cnt_r   <= dwell_r;
              state_r <= ST_SETTLE;
            end else begin
              state_r <= ST_PRESENT;
            end
          end
        end
        ST_PRESENT: begin
          // Frame is published one cycle after the last sample lands, so
          // frame_data only ever changes together with a rising frame_valid.
          if (!frame_valid_r) begin
            frame_valid_r <= 1'b1;
            frame_data_r  <= acc_r;
          end else if (frame_ready) begin
            frame_valid_r <= 1'b0;
            if (cont_r) begin
              acc_r   <= 4'b0000;
              sel_r   <= first_ch_s;
              cnt_r   <= dwell_r;
              state_r <= ST_SETTLE;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          frame_valid_r <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign s0          = sel_r[0];
  assign s1          = sel_r[1];
  assign frame_data  = frame_data_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

endmodule
